// File: rtl/led_pattern_sequencer_pkg.sv
// Shared types for the LED pattern sequencer: modes, parser states, command opcodes
// and the pattern advance rule used by both automatic and single steps.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_STOP   = 2'd0,
        MODE_ROTATE = 2'd1,
        MODE_COUNT  = 2'd2,
        MODE_FILL   = 2'd3
    } mode_t;

    typedef enum logic {
        PARSE_IDLE     = 1'b0,
        PARSE_WAIT_PAT = 1'b1
    } parse_state_t;

    localparam logic [1:0] OP_SET_MODE   = 2'b00;
    localparam logic [1:0] OP_SET_PERIOD = 2'b01;
    localparam logic [1:0] OP_LOAD       = 2'b10;
    localparam logic [1:0] OP_SINGLE     = 2'b11;

    // STOP falls through to the FILL rule so a single-step while stopped still moves the bank.
    function automatic logic [7:0] next_pattern(input mode_t mode, input logic [7:0] leds);
        logic [7:0] result;
        case (mode)
            MODE_ROTATE: result = (leds == 8'h00) ? 8'h01 : {leds[6:0], leds[7]};
            MODE_COUNT:  result = leds + 8'h01;
            MODE_FILL:   result = (leds == 8'hFF) ? 8'h00 : {1'b1, leds[7:1]};
            default:     result = (leds == 8'hFF) ? 8'h00 : {1'b1, leds[7:1]};
        endcase
        return result;
    endfunction

endpackage

// File: rtl/led_pattern_sequencer_tick_prescaler.sv
// Free-running prescaler: counts 0..TICK_DIV-1 and emits a registered one-cycle TICK on each wrap.
module tick_prescaler #(
    parameter int TICK_DIV = 10_000_000
) (
    input  logic CLK,
    input  logic RESET,
    output logic TICK
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             tick_r;

    // Prescale counter with the wrap pulse registered alongside it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (cnt_r == LAST_COUNT) begin
            cnt_r  <= '0;
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
            tick_r <= 1'b0;
        end
    end

    assign TICK = tick_r;

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED bank sequencer: byte-command parser, step counter and pattern register.
// The tick prescaler is the only sub-block; everything else is sequenced here.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int         TICK_DIV   = 10_000_000,
    parameter logic [1:0] RESET_MODE = 2'd3,
    parameter int         LED_W      = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CMD_VALID,
    input  logic [7:0]       CMD_DATA,
    output logic             CMD_READY,
    output logic [LED_W-1:0] LEDS,
    output logic             TICK,
    output logic             STEP,
    output logic [1:0]       MODE
);

    logic             tick_s;
    logic             accept_s;
    logic             step_due_s;
    logic             set_mode_s;
    logic             set_period_s;
    logic             load_op_s;
    logic             single_s;
    logic             load_data_s;

    logic [5:0]       period_r;
    logic [5:0]       step_cnt_r;
    logic [LED_W-1:0] leds_r;
    mode_t            mode_r;
    parse_state_t     state_r;
    logic             ready_r;
    logic             step_r;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .CLK   (CLK),
        .RESET (RESET),
        .TICK  (tick_s)
    );

    assign accept_s   = CMD_VALID && ready_r;
    assign step_due_s = tick_s && (step_cnt_r == (period_r - 6'd1));

    // Decode the accepted byte: opcode in IDLE, raw pattern data in WAIT_PAT.
    always_comb begin
        set_mode_s   = 1'b0;
        set_period_s = 1'b0;
        load_op_s    = 1'b0;
        single_s     = 1'b0;
        load_data_s  = 1'b0;
        if (accept_s && (state_r == PARSE_IDLE)) begin
            case (CMD_DATA[7:6])
                OP_SET_MODE:   set_mode_s   = 1'b1;
                OP_SET_PERIOD: set_period_s = 1'b1;
                OP_LOAD:       load_op_s    = 1'b1;
                OP_SINGLE:     single_s     = 1'b1;
                default:       set_mode_s   = 1'b0;
            endcase
        end else if (accept_s) begin
            load_data_s = 1'b1;
        end else begin
            load_data_s = 1'b0;
        end
    end

    // Step period and tick counter; mode/period changes restart the count.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            period_r   <= 6'd1;
            step_cnt_r <= 6'd0;
        end else begin
            if (set_period_s) begin
                period_r <= (CMD_DATA[5:0] == 6'd0) ? 6'd1 : CMD_DATA[5:0];
            end else begin
                period_r <= period_r;
            end
            if (set_mode_s || set_period_s || step_due_s) begin
                step_cnt_r <= 6'd0;
            end else if (tick_s) begin
                step_cnt_r <= step_cnt_r + 6'd1;
            end else begin
                step_cnt_r <= step_cnt_r;
            end
        end
    end

    // Parser FSM with the LED, mode, ready and step-pulse registers it drives.
    // A LEDS-writing command beats a coincident automatic step; the step uses the old mode.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r <= PARSE_IDLE;
            leds_r  <= '0;
            mode_r  <= mode_t'(RESET_MODE);
            ready_r <= 1'b0;
            step_r  <= 1'b0;
        end else begin
            ready_r <= 1'b1;
            if (load_data_s) begin
                leds_r <= CMD_DATA;
                step_r <= 1'b0;
            end else if (single_s || (step_due_s && (mode_r != MODE_STOP))) begin
                leds_r <= next_pattern(mode_r, leds_r);
                step_r <= 1'b1;
            end else begin
                leds_r <= leds_r;
                step_r <= 1'b0;
            end
            if (set_mode_s) begin
                mode_r <= mode_t'(CMD_DATA[1:0]);
            end else begin
                mode_r <= mode_r;
            end
            case (state_r)
                PARSE_IDLE:     state_r <= load_op_s ? PARSE_WAIT_PAT : PARSE_IDLE;
                PARSE_WAIT_PAT: state_r <= load_data_s ? PARSE_IDLE : PARSE_WAIT_PAT;
                default:        state_r <= PARSE_IDLE;
            endcase
        end
    end

    assign CMD_READY = ready_r;
    assign LEDS      = leds_r;
    assign TICK      = tick_s;
    assign STEP      = step_r;
    assign MODE      = mode_r;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: reference model compared every cycle plus directed literal checks.
module tb_led_pattern_sequencer;

    localparam int DIV = 4;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       CMD_VALID = 1'b0;
    logic [7:0] CMD_DATA = 8'h00;
    logic       CMD_READY;
    logic [7:0] LEDS;
    logic       TICK;
    logic       STEP;
    logic [1:0] MODE;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit cmp_en = 1'b0;

    led_pattern_sequencer #(.TICK_DIV(DIV), .RESET_MODE(2'd3), .LED_W(8)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .CMD_VALID (CMD_VALID),
        .CMD_DATA  (CMD_DATA),
        .CMD_READY (CMD_READY),
        .LEDS      (LEDS),
        .TICK      (TICK),
        .STEP      (STEP),
        .MODE      (MODE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- behavioural model ----------------
    typedef struct {
        int leds;
        int mode;
        int period;
        int since;
        int edges;
        bit waiting;
        bit step;
        bit tick;
        bit ready;
    } model_t;

    model_t m;

    function automatic int apply_rule(input int mode, input int x);
        if (mode == 1) return (x == 0) ? 1 : (((x << 1) | (x >> 7)) & 255);
        if (mode == 2) return (x + 1) % 256;
        return (x == 255) ? 0 : ((x >> 1) | 128);
    endfunction

    function automatic model_t model_reset();
        model_t r;
        r.leds = 0; r.mode = 3; r.period = 1; r.since = 0; r.edges = 0;
        r.waiting = 1'b0; r.step = 1'b0; r.tick = 1'b0; r.ready = 1'b0;
        return r;
    endfunction

    function automatic model_t model_next(input model_t c, input bit valid, input int data);
        model_t n = c;
        bit acc = valid && c.ready;
        bit due = 1'b0;
        int op  = (data >> 6) & 3;
        n.step = 1'b0;
        if (c.tick) begin
            n.since = c.since + 1;
            if (n.since >= c.period) begin
                due = 1'b1;
                n.since = 0;
            end
        end
        if (acc && c.waiting) begin
            n.leds = data;
            n.waiting = 1'b0;
        end else if (acc && op == 3) begin
            n.leds = apply_rule((c.mode == 0) ? 3 : c.mode, c.leds);
            n.step = 1'b1;
        end else if (due && c.mode != 0) begin
            n.leds = apply_rule(c.mode, c.leds);
            n.step = 1'b1;
        end
        if (acc && !c.waiting) begin
            if (op == 0) begin
                n.mode = data & 3;
                n.since = 0;
            end else if (op == 1) begin
                n.period = ((data & 63) == 0) ? 1 : (data & 63);
                n.since = 0;
            end else if (op == 2) begin
                n.waiting = 1'b1;
            end
        end
        n.edges = c.edges + 1;
        n.tick  = (n.edges % DIV) == 0;
        n.ready = 1'b1;
        return n;
    endfunction

    always @(posedge CLK or posedge RESET) begin
        if (RESET) m <= model_reset();
        else       m <= model_next(m, CMD_VALID, int'(CMD_DATA));
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    always @(negedge CLK) begin
        if (cmp_en) begin
            check("model_leds",  int'(LEDS),      m.leds);
            check("model_mode",  int'(MODE),      m.mode);
            check("model_tick",  int'(TICK),      int'(m.tick));
            check("model_step",  int'(STEP),      int'(m.step));
            check("model_ready", int'(CMD_READY), int'(m.ready));
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic send(input logic [7:0] b);
        CMD_VALID = 1'b1;
        CMD_DATA  = b;
        @(negedge CLK);
        CMD_VALID = 1'b0;
        CMD_DATA  = 8'h00;
    endtask

    task automatic wait_step(input int max_cycles, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(negedge CLK);
            if (STEP) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no STEP within %0d cycles, expected one", name, max_cycles);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    int c0;
    int c1;
    int n_ticks;
    int n_steps;
    int fill_seq[9] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'h00};
    int rot_seq[9]  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};

    initial begin
        // Reset state
        @(negedge CLK);
        cmp_en = 1'b1;
        @(negedge CLK);
        check("reset_leds",  int'(LEDS), 8'h00);
        check("reset_mode",  int'(MODE), 3);
        check("reset_ready", int'(CMD_READY), 0);
        RESET = 1'b0;
        c0 = cyc;

        // 1. FILL after reset, step every 4 cycles, 00 after FF
        for (int i = 0; i < 9; i++) begin
            wait_step(20, "fill_step");
            check("fill_leds", int'(LEDS), fill_seq[i]);
            if (i == 0) check("first_step_latency", cyc - c0, 5);
            else        check("fill_spacing", cyc - c1, 4);
            c1 = cyc;
        end

        // 2. ROTATE at period 1
        send(8'h01);
        send(8'h41);
        for (int i = 0; i < 9; i++) begin
            wait_step(20, "rotate_step");
            check("rotate_leds", int'(LEDS), rot_seq[i]);
        end

        // 3. STOP, LOAD A5, no steps, SINGLE uses FILL rule
        send(8'h00);
        send(8'h80);
        send(8'hA5);
        check("load_leds", int'(LEDS), 8'hA5);
        check("stop_mode", int'(MODE), 0);
        n_ticks = 0;
        n_steps = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (TICK) n_ticks++;
            if (STEP) n_steps++;
        end
        check("stop_steps", n_steps, 0);
        check("stop_ticks", n_ticks, 10);
        check("stop_leds", int'(LEDS), 8'hA5);
        send(8'hC0);
        check("single_leds", int'(LEDS), 8'hD2);
        check("single_step", int'(STEP), 1);

        // 4. COUNT, period 3 then period 0 -> 1
        send(8'h02);
        send(8'h43);
        wait_step(40, "count_step");
        check("count_leds1", int'(LEDS), 8'hD3);
        c1 = cyc;
        wait_step(40, "count_step");
        check("count_leds2", int'(LEDS), 8'hD4);
        check("period3_spacing", cyc - c1, 12);
        send(8'h40);
        wait_step(20, "count_step");
        check("count_leds3", int'(LEDS), 8'hD5);
        c1 = cyc;
        wait_step(20, "count_step");
        check("count_leds4", int'(LEDS), 8'hD6);
        check("period0_spacing", cyc - c1, 4);
        c1 = cyc;

        // 5. LOAD data lands in the cycle an automatic step is due
        idle(2);
        send(8'h80);
        send(8'h5A);
        check("collide_leds", int'(LEDS), 8'h5A);
        check("collide_step", int'(STEP), 0);
        wait_step(20, "after_collide");
        check("after_collide_leds", int'(LEDS), 8'h5B);
        check("after_collide_spacing", cyc - c1, 8);

        // 6. Reset while waiting for pattern data
        send(8'h80);
        send(8'h3C);
        check("load3c_leds", int'(LEDS), 8'h3C);
        send(8'h80);
        #2;
        RESET = 1'b1;
        #1;
        check("async_reset_leds",  int'(LEDS), 8'h00);
        check("async_reset_mode",  int'(MODE), 3);
        check("async_reset_ready", int'(CMD_READY), 0);
        idle(3);
        RESET = 1'b0;
        @(negedge CLK);
        check("ready_after_release", int'(CMD_READY), 1);
        send(8'h02);
        check("post_reset_mode", int'(MODE), 2);
        check("post_reset_leds", int'(LEDS), 8'h00);
        idle(30);

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
